prog_run_ctrl: RTL and testbench

//  Parametrised program-run controller placed between the test bench and the core.

---
 rtl/prog_run_ctrl_pkg.sv | 27 ++
 rtl/prog_run_ctrl_sat_counter.sv | 35 +++
 rtl/prog_run_ctrl.sv | 115 +++++++++++
 tb/tb_prog_run_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_run_ctrl_pkg.sv
// Shared types and helpers for the program-run controller.
// Holds the FSM state encoding and the start-address table lookup.
package prog_run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN,
      DONE
   } run_state_t;

   localparam int unsigned TBL_MAX = 4096;

   // Entry idx of a packed table of a-bit addresses.
   function automatic logic [63:0] start_of(
      input logic [TBL_MAX-1:0] tbl,
      input int unsigned        idx,
      input int unsigned        a
   );
      logic [TBL_MAX-1:0] sh;
      logic [63:0]        mask;
      sh   = tbl >> (idx * a);
      mask = (64'd1 << a) - 64'd1;
      return 64'(sh) & mask;
   endfunction

endpackage

// File: rtl/prog_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/prog_run_ctrl.sv
// Program-run controller: sequences programs from a start table,
// owns the req/ack handshake, RUN-cycle count and watchdog.
module prog_run_ctrl
   import prog_run_ctrl_pkg::*;
#(
   parameter int unsigned             A         = 16,
   parameter int unsigned             NPROG     = 3,
   parameter logic [NPROG*A-1:0]      START_TBL = '0,
   parameter logic [A-1:0]            HALT_ADDR = {A{1'b1}},
   parameter int unsigned             CW        = 16,
   parameter int unsigned             TIMEOUT   = 16'hFFFF,
   localparam int unsigned            IW        = (NPROG > 1) ? $clog2(NPROG) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [A-1:0]  pc,
   output logic          init,
   output logic [A-1:0]  start_pc,
   output logic          run_en,
   output logic          ack,
   output logic [IW-1:0] prog_idx,
   output logic [CW-1:0] cycles,
   output logic          timeout
);

   run_state_t    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          to_q, to_d;

   logic          cnt_clr;
   logic          cnt_inc;
   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_p1;
   logic [CW-1:0] cnt_sat;

   sat_counter #(
      .CW (CW)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .cnt   (cnt)
   );

   // Unsaturated +1 for the watchdog compare, saturated for the report.
   assign cnt_p1  = {1'b0, cnt} + 1'b1;
   assign cnt_sat = cnt_p1[CW] ? cnt : cnt_p1[CW-1:0];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cycles_d = cycles_q;
      to_d     = to_q;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = INIT;
               cnt_clr = 1'b1;
            end
         end
         INIT: begin
            state_d = RUN;
         end
         RUN: begin
            cnt_inc = 1'b1;
            if (pc == HALT_ADDR) begin
               state_d  = DONE;
               cycles_d = cnt_sat;
               to_d     = 1'b0;
            end else if (cnt_p1 == (CW+1)'(TIMEOUT)) begin
               state_d  = DONE;
               cycles_d = CW'(TIMEOUT);
               to_d     = 1'b1;
            end
         end
         DONE: begin
            if (!req) begin
               state_d = IDLE;
               idx_d   = (idx_q == IW'(NPROG - 1)) ? '0 : idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cycles_q <= '0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cycles_q <= cycles_d;
         to_q     <= to_d;
      end
   end

   assign init     = (state_q == INIT);
   assign run_en   = (state_q == RUN);
   assign ack      = (state_q == DONE);
   assign prog_idx = idx_q;
   assign cycles   = cycles_q;
   assign timeout  = to_q;
   assign start_pc = A'(start_of(TBL_MAX'(START_TBL), int'(idx_q), A));

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Scoreboard bench for prog_run_ctrl: stimulus pushes expectations,
// a negedge monitor pops them on init and on each rising ack.
module tb_prog_run_ctrl;

   localparam int          A     = 9;
   localparam int          NPROG = 3;
   localparam int          CW    = 16;
   localparam int          TO    = 600;
   localparam logic [8:0]  HALT  = 9'h1FF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [8:0]  pc;
   logic        init;
   logic [8:0]  start_pc;
   logic        run_en;
   logic        ack;
   logic [1:0]  prog_idx;
   logic [15:0] cycles;
   logic        timeout;

   prog_run_ctrl #(
      .A         (A),
      .NPROG     (NPROG),
      .START_TBL ({9'h40, 9'h20, 9'h00}),
      .HALT_ADDR (HALT),
      .CW        (CW),
      .TIMEOUT   (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .pc       (pc),
      .init     (init),
      .start_pc (start_pc),
      .run_en   (run_en),
      .ack      (ack),
      .prog_idx (prog_idx),
      .cycles   (cycles),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int cyc;
      bit to;
   } done_t;

   int         vec = 0;
   int         bad = 0;
   int         m_idx;
   logic [8:0] tbl_m [3];
   int         sq [$];
   done_t      dq [$];
   done_t      mon_d;
   int         mon_s;
   logic       ack_p = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] pc_at(input int mode, input logic [8:0] s,
                                        input int j, input int n);
      case (mode)
         0:       return s + 9'(j - 1);
         1:       return 9'h005;
         default: return (j == n) ? HALT : 9'h005;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         if (init) begin
            if (sq.size() == 0) begin
               chk("init_unexpected", 1, 0);
            end else begin
               mon_s = sq.pop_front();
               chk("start_pc", start_pc, mon_s);
               chk("init_run_en", run_en, 0);
            end
         end
         if (ack && !ack_p) begin
            if (dq.size() == 0) begin
               chk("ack_unexpected", 1, 0);
            end else begin
               mon_d = dq.pop_front();
               chk("prog_idx", prog_idx, mon_d.idx);
               chk("cycles", cycles, mon_d.cyc);
               chk("timeout", timeout, mon_d.to);
            end
         end
         ack_p <= ack;
      end else begin
         ack_p <= 1'b0;
      end
   end

   // mode 0: pc counts up from start; 1: pc stuck; 2: stuck then HALT at run cycle n
   task automatic run_prog(input int mode, input int n, input int hold,
                           input int rst_at);
      int         len;
      bit         to;
      logic [8:0] s;
      s   = tbl_m[m_idx];
      len = TO;
      to  = 1'b1;
      for (int j = 1; j <= TO; j++) begin
         if (pc_at(mode, s, j, n) == HALT) begin
            len = j;
            to  = 1'b0;
            break;
         end
      end
      sq.push_back(int'(s));
      if (rst_at == 0) dq.push_back('{m_idx, len, to});
      @(negedge clk);
      req = 1'b1;
      pc  = HALT;
      @(negedge clk);
      req = 1'($urandom_range(0, 1));
      for (int j = 1; j <= len; j++) begin
         @(negedge clk);
         pc  = pc_at(mode, s, j, n);
         req = 1'($urandom_range(0, 1));
         if (j == rst_at) begin
            #3 reset = 1'b0;
            #1;
            chk("rst_run_en", run_en, 0);
            chk("rst_ack", ack, 0);
            chk("rst_idx", prog_idx, 0);
            chk("rst_cycles", cycles, 0);
            chk("rst_timeout", timeout, 0);
            @(negedge clk);
            reset = 1'b1;
            req   = 1'b0;
            pc    = HALT;
            m_idx = 0;
            return;
         end
      end
      @(negedge clk);
      chk("ack_latency", ack, 1);
      chk("done_run_en", run_en, 0);
      pc  = HALT;
      req = (hold != 0);
      repeat (hold) @(negedge clk);
      if (hold != 0) chk("ack_held", ack, 1);
      req = 1'b0;
      @(negedge clk);
      chk("ack_drop", ack, 0);
      m_idx = (m_idx + 1) % NPROG;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl_m[0] = 9'h00;
      tbl_m[1] = 9'h20;
      tbl_m[2] = 9'h40;
      m_idx    = 0;
      reset    = 1'b0;
      req      = 1'b0;
      pc       = 9'h000;
      #12;
      chk("reset_init", init, 0);
      chk("reset_run_en", run_en, 0);
      chk("reset_ack", ack, 0);
      chk("reset_idx", prog_idx, 0);
      chk("reset_cycles", cycles, 0);
      chk("reset_timeout", timeout, 0);
      @(negedge clk);
      reset = 1'b1;

      repeat (4) run_prog(0, 0, 0, 0);
      run_prog(1, 0, 0, 0);
      run_prog(0, 0, 0, 0);
      run_prog(2, TO, 0, 0);
      run_prog(2, 1, 0, 0);
      run_prog(0, 0, 20, 0);
      run_prog(0, 0, 0, 37);
      run_prog(2, 5, 0, 0);
      repeat (6) begin
         run_prog(int'($urandom_range(0, 2)), int'($urandom_range(1, TO)),
                  int'($urandom_range(0, 4)), 0);
      end

      repeat (3) @(negedge clk);
      chk("start_queue_empty", sq.size(), 0);
      chk("done_queue_empty", dq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
